sram_line_scanout: RTL and testbench

- Read side of the SRAM framebuffer. The rasterizer writes one pixel bit per address {x[8:0], y[8:0]} into SRAM DQ[0].
- This block streams one framebuffer row per display line from SRAM into a ping-pong line buffer.
- It serves pixels to the VGA timing logic from the front buffer with fixed 1-cycle latency.
- It owns the SRAM pins only while the framebuffer is in display mode.

---
 rtl/sram_line_scanout_if.sv | 26 ++
 rtl/sram_line_scanout.sv | 147 ++++++++++++++
 tb/tb_sram_line_scanout.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_line_scanout_if.sv
// Display-side bus of the framebuffer scan-out block.
//   line_start : one-cycle pulse at the start of each display line
//   next_y     : row to fetch, sampled on line_start
//   pix_x      : display x coordinate requested this cycle
//   pix        : registered pixel from the front line buffer
//   fetch_busy : a row fetch (or the reset-time buffer clear) is in progress
//   underrun   : sticky, a line_start arrived while a fetch was still running
// The "master" modport is the VGA timing side; "slave" is the scan-out block.
interface sram_line_scanout_if;
  logic       line_start;
  logic [8:0] next_y;
  logic [8:0] pix_x;
  logic       pix;
  logic       fetch_busy;
  logic       underrun;

  modport master (
    output line_start, next_y, pix_x,
    input  pix, fetch_busy, underrun
  );

  modport slave (
    input  line_start, next_y, pix_x,
    output pix, fetch_busy, underrun
  );
endinterface

// File: rtl/sram_line_scanout.sv
// Read side of the SRAM framebuffer. Each display line one framebuffer row
// is streamed from SRAM DQ[0] into the back half of a ping-pong line buffer
// while the VGA logic reads pixels from the front half with 1-cycle latency.
// Ports:
//   CLOCK_50  : system clock, all logic on its rising edge
//   rst       : synchronous reset, active-high
//   bus       : display-side interface (slave modport)
//   SRAM_ADDR : {fx, fy} of the pixel being fetched, held while idle
//   SRAM_DQ   : never driven by this block; only bit 0 is read
//   SRAM_*_N  : fixed read-mode strobes
module sram_line_scanout #(
  parameter int LINE_W    = 320,
  parameter int READ_WAIT = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  sram_line_scanout_if.slave   bus,
  output logic [17:0]          SRAM_ADDR,
  inout  wire  [15:0]          SRAM_DQ,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_CE_N
);

  localparam int              WW        = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
  localparam logic [WW-1:0]   WAIT_LAST = WW'(READ_WAIT);
  localparam logic [8:0]      X_LAST    = 9'(LINE_W - 1);
  localparam logic [9:0]      X_LIMIT   = 10'(LINE_W);

  typedef enum logic [1:0] {
    S_CLEAR,   // zeroing both line buffers after reset
    S_IDLE,
    S_FETCH
  } state_t;

  state_t        state, next_state;
  logic [8:0]    clr_idx;
  logic [8:0]    fx, fy;
  logic [WW-1:0] wcnt;
  logic          front_sel;
  logic          busy_q;
  logic          underrun_q;
  logic          pix_q;

  logic line_buf [2][LINE_W];

  logic sample, last_sample, busy_now, start, swap, hit_underrun;

  // Fixed read-mode strobes; the data bus is never driven from this side.
  assign SRAM_WE_N = 1'b1;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_DQ   = {16{1'bz}};

  // Upper data bits carry nothing for a 1-bpp framebuffer.
  wire unused_dq = ^SRAM_DQ[15:1];

  assign bus.pix        = pix_q;
  assign bus.fetch_busy = busy_q;
  assign bus.underrun   = underrun_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state   = state;
    sample       = (state == S_FETCH) && (wcnt == WAIT_LAST);
    last_sample  = sample && (fx == X_LAST);
    // A line_start coinciding with the final sample sees the fetch as done.
    busy_now     = (state == S_FETCH) && !last_sample;
    start        = bus.line_start && (state != S_CLEAR);
    swap         = start && !busy_now;
    hit_underrun = start && busy_now;

    unique case (state)
      S_CLEAR: if (clr_idx == X_LAST) next_state = S_IDLE;
      S_IDLE:  if (start)             next_state = S_FETCH;
      S_FETCH: begin
        if (start)            next_state = S_FETCH;
        else if (last_sample) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state      <= S_CLEAR;
      clr_idx    <= '0;
      front_sel  <= 1'b0;
      fx         <= '0;
      fy         <= '0;
      wcnt       <= '0;
      SRAM_ADDR  <= '0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != S_IDLE);

      if (state == S_CLEAR) clr_idx <= clr_idx + 9'd1;

      if (start) begin
        // Restart (normal or after an abort) at pixel 0 of the new row.
        fy        <= bus.next_y;
        fx        <= '0;
        wcnt      <= '0;
        SRAM_ADDR <= {9'd0, bus.next_y};
        if (swap)         front_sel  <= ~front_sel;
        if (hit_underrun) underrun_q <= 1'b1;
      end else if (state == S_FETCH) begin
        if (wcnt == WAIT_LAST) begin
          if (fx != X_LAST) begin
            fx        <= fx + 9'd1;
            wcnt      <= '0;
            SRAM_ADDR <= {fx + 9'd1, fy};
          end
        end else begin
          wcnt <= wcnt + WW'(1);
        end
      end
    end
  end

  // NOTE: the line buffers have no reset branch; they are zeroed one entry
  // per cycle by the clear sequence so they can map onto plain RAM.
  always_ff @(posedge CLOCK_50) begin
    if (state == S_CLEAR) begin
      line_buf[0][clr_idx] <= 1'b0;
      line_buf[1][clr_idx] <= 1'b0;
    end else if (sample) begin
      // Written with the pre-swap select, so a coinciding swap shows it.
      line_buf[~front_sel][fx] <= SRAM_DQ[0];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst || state == S_CLEAR)          pix_q <= 1'b0;
    else if ({1'b0, bus.pix_x} < X_LIMIT) pix_q <= line_buf[front_sel][bus.pix_x];
    else                                  pix_q <= 1'b0;
  end

endmodule

// File: tb/tb_sram_line_scanout.sv
// Testbench for sram_line_scanout: a slow-SRAM model drives DQ[0] from
// per-row pixel tables, and a line-level model (front/back row snapshots)
// predicts every pixel, fetch length, address and underrun flag.
module tb_sram_line_scanout;
  localparam int LINE_W    = 320;
  localparam int READ_WAIT = 2;
  localparam int FETCH_CYC = LINE_W * (READ_WAIT + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [17:0] sram_addr;
  wire  [15:0] sram_dq;
  wire         we_n, oe_n, ub_n, lb_n, ce_n;

  sram_line_scanout_if vif();

  sram_line_scanout #(.LINE_W(LINE_W), .READ_WAIT(READ_WAIT)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .bus      (vif),
    .SRAM_ADDR(sram_addr),
    .SRAM_DQ  (sram_dq),
    .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n),
    .SRAM_UB_N(ub_n),
    .SRAM_LB_N(lb_n),
    .SRAM_CE_N(ce_n)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pin_errs = 0;

  // Framebuffer contents: row_data[y][x], rows 0..7 used.
  logic [511:0] row_data [8];

  // Slow SRAM: data is only correct once an address has been held for
  // READ_WAIT+1 cycles; before that the bit reads inverted.
  logic [17:0] last_addr = '0;
  int          age = 0;
  logic        dq_bit;
  always @(negedge clk) begin
    if (sram_addr !== last_addr) begin
      last_addr = sram_addr;
      age = 1;
    end else if (age < 1000) begin
      age++;
    end
  end
  assign dq_bit  = row_data[sram_addr[2:0]][sram_addr[17:9]];
  assign sram_dq = {15'h0, (age >= READ_WAIT + 1) ? dq_bit : ~dq_bit};

  always @(negedge clk) begin
    if (we_n !== 1'b1 || oe_n !== 1'b0 || ub_n !== 1'b0 ||
        lb_n !== 1'b0 || ce_n !== 1'b0 || sram_dq[15:1] !== 15'h0)
      pin_errs++;
  end

  // Line-level model: contents of the front and back buffers.
  logic [511:0] front_bits, back_bits;
  logic [2:0]   pend_y;
  logic         exp_underrun;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_line(input logic [8:0] y);
    vif.line_start = 1'b1;
    vif.next_y     = y;
    tick();
    vif.line_start = 1'b0;
  endtask

  task automatic model_start(input logic [8:0] y, input bit busy);
    if (busy) exp_underrun = 1'b1;
    else      front_bits   = back_bits;
    pend_y = y[2:0];
  endtask

  task automatic model_done();
    back_bits = row_data[pend_y];
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (vif.fetch_busy === 1'b1 && cyc < 4000) begin
      cyc++;
      tick();
    end
    if (cyc >= 4000) begin
      failures++;
      $display("FAIL wait_idle: fetch_busy still high after %0d cycles", cyc);
    end
  endtask

  task automatic sweep_pixels(input string tag);
    for (int x = 0; x < LINE_W; x++) begin
      vif.pix_x = 9'(x);
      tick();
      checks++;
      if (vif.pix !== front_bits[x]) begin
        failures++;
        $display("FAIL %s pix[%0d]: got %b want %b", tag, x, vif.pix, front_bits[x]);
      end
    end
  endtask

  task automatic random_row(input int r);
    for (int w = 0; w < 16; w++) row_data[r][w*32 +: 32] = $urandom();
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    vif.pix_x = 9'd0;
    repeat (3) tick();
    checks++;
    if (vif.pix !== 1'b0 || vif.fetch_busy !== 1'b0 || vif.underrun !== 1'b0 || sram_addr !== 18'd0) begin
      failures++;
      $display("FAIL reset_values: pix=%b busy=%b underrun=%b addr=%h want 0/0/0/0",
               vif.pix, vif.fetch_busy, vif.underrun, sram_addr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (vif.fetch_busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_busy: got %b want 1", vif.fetch_busy);
    end
    pulse_line(9'd5);                // must be ignored during the clear
    wait_idle(cyc);
    checks++;
    if (cyc > LINE_W) begin
      failures++;
      $display("FAIL clear_length: got %0d cycles want <= %0d", cyc, LINE_W);
    end
    repeat (5) tick();
    checks++;
    if (vif.fetch_busy !== 1'b0 || sram_addr !== 18'd0) begin
      failures++;
      $display("FAIL clear_ignores_line_start: busy=%b addr=%h want 0/0", vif.fetch_busy, sram_addr);
    end
    front_bits   = '0;
    back_bits    = '0;
    exp_underrun = 1'b0;
    sweep_pixels("after_clear");
  endtask

  task automatic test_basic_fetch();
    int cyc;
    logic [17:0] exp_a;
    for (int r = 0; r < 8; r++)
      for (int x = 0; x < 512; x++) row_data[r][x] = 1'(x) ^ 1'(r);
    pulse_line(9'd2);
    model_start(9'd2, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      exp_a = {(c <= 3) ? 9'd0 : 9'd1, 9'd2};
      checks++;
      if (sram_addr !== exp_a) begin
        failures++;
        $display("FAIL addr_cycle%0d: got %h want %h", c, sram_addr, exp_a);
      end
      tick();
    end
    wait_idle(cyc);
    checks++;
    if (cyc + 6 !== FETCH_CYC) begin
      failures++;
      $display("FAIL busy_length: got %0d want %0d", cyc + 6, FETCH_CYC);
    end
    checks++;
    if (sram_addr !== {9'(LINE_W - 1), 9'd2}) begin
      failures++;
      $display("FAIL addr_hold_idle: got %h want %h", sram_addr, {9'(LINE_W - 1), 9'd2});
    end
    model_done();
    pulse_line(9'd3);
    model_start(9'd3, 1'b0);
    sweep_pixels("row2_front");
    for (int i = 0; i < 2; i++) begin
      vif.pix_x = (i == 0) ? 9'd320 : 9'd511;
      tick();
      checks++;
      if (vif.pix !== 1'b0) begin
        failures++;
        $display("FAIL out_of_range x=%0d: got %b want 0", vif.pix_x, vif.pix);
      end
    end
    wait_idle(cyc);
    model_done();
  endtask

  task automatic test_random_lines();
    int cyc;
    logic [8:0] y, x;
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < 8; r++) random_row(r);
      y = 9'($urandom_range(0, 7));
      pulse_line(y);
      model_start(y, 1'b0);
      for (int k = 0; k < 40; k++) begin
        x = 9'($urandom_range(0, 511));
        vif.pix_x = x;
        tick();
        checks++;
        if (vif.pix !== ((x < 9'(LINE_W)) ? front_bits[x] : 1'b0)) begin
          failures++;
          $display("FAIL random_pix it%0d x=%0d: got %b want %b", it, x, vif.pix,
                   (x < 9'(LINE_W)) ? front_bits[x] : 1'b0);
        end
      end
      wait_idle(cyc);
      checks++;
      if (cyc + 40 !== FETCH_CYC) begin
        failures++;
        $display("FAIL random_busy it%0d: got %0d want %0d", it, cyc + 40, FETCH_CYC);
      end
      model_done();
    end
    pulse_line(9'd0);
    model_start(9'd0, 1'b0);
    sweep_pixels("random_front");
    wait_idle(cyc);
    model_done();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [8:0] ya, yb;
    ya = 9'($urandom_range(0, 7));
    yb = 9'($urandom_range(0, 7));
    pulse_line(ya);
    model_start(ya, 1'b0);
    repeat (FETCH_CYC - 1) tick();
    checks++;
    if (vif.fetch_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_busy_before_last: got %b want 1", vif.fetch_busy);
    end
    pulse_line(yb);                  // sampled on the final-sample edge
    model_done();
    model_start(yb, 1'b0);
    checks++;
    if (vif.underrun !== 1'b0 || vif.fetch_busy !== 1'b1 || sram_addr !== {9'd0, yb}) begin
      failures++;
      $display("FAIL b2b_restart: underrun=%b busy=%b addr=%h want 0/1/%h",
               vif.underrun, vif.fetch_busy, sram_addr, {9'd0, yb});
    end
    vif.pix_x = 9'(LINE_W - 1);
    tick();
    checks++;
    if (vif.pix !== front_bits[LINE_W-1]) begin
      failures++;
      $display("FAIL b2b_last_pixel: got %b want %b", vif.pix, front_bits[LINE_W-1]);
    end
    sweep_pixels("b2b_front");
    wait_idle(cyc);
    model_done();
  endtask

  task automatic test_underrun();
    int cyc;
    logic [8:0] ya, yb;
    ya = 9'($urandom_range(0, 7));
    yb = 9'((ya + 9'd1) & 9'd7);
    pulse_line(ya);
    model_start(ya, 1'b0);
    repeat (499) tick();
    pulse_line(yb);
    model_start(yb, 1'b1);
    checks++;
    if (vif.underrun !== exp_underrun || vif.fetch_busy !== 1'b1 || sram_addr !== {9'd0, yb}) begin
      failures++;
      $display("FAIL underrun_restart: underrun=%b busy=%b addr=%h want %b/1/%h",
               vif.underrun, vif.fetch_busy, sram_addr, exp_underrun, {9'd0, yb});
    end
    sweep_pixels("underrun_front_kept");
    wait_idle(cyc);
    checks++;
    if (cyc + LINE_W !== FETCH_CYC) begin
      failures++;
      $display("FAIL underrun_refetch_len: got %0d want %0d", cyc + LINE_W, FETCH_CYC);
    end
    model_done();
    pulse_line(9'd6);
    model_start(9'd6, 1'b0);
    sweep_pixels("underrun_new_row");
    wait_idle(cyc);
    model_done();
    checks++;
    if (vif.underrun !== exp_underrun) begin
      failures++;
      $display("FAIL underrun_sticky: got %b want %b", vif.underrun, exp_underrun);
    end
  endtask

  task automatic test_rst_midfetch();
    int cyc;
    pulse_line(9'd1);
    model_start(9'd1, 1'b0);
    vif.pix_x = 9'd1;
    repeat (449) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (vif.fetch_busy !== 1'b0 || vif.pix !== 1'b0 || sram_addr !== 18'd0 || vif.underrun !== 1'b0) begin
      failures++;
      $display("FAIL rst_midfetch: busy=%b pix=%b addr=%h underrun=%b want 0/0/0/0",
               vif.fetch_busy, vif.pix, sram_addr, vif.underrun);
    end
    rst = 1'b0;
    front_bits   = '0;
    back_bits    = '0;
    exp_underrun = 1'b0;
    tick();
    wait_idle(cyc);
    sweep_pixels("rst_cleared");
    checks++;
    if (pin_errs !== 0) begin
      failures++;
      $display("FAIL sram_pins: %0d cycles with bad strobes or driven DQ, want 0", pin_errs);
    end
  endtask

  initial begin
    vif.line_start = 1'b0;
    vif.next_y     = 9'd0;
    vif.pix_x      = 9'd0;
    for (int r = 0; r < 8; r++) row_data[r] = '0;
    test_reset();
    test_basic_fetch();
    test_random_lines();
    test_back_to_back();
    test_underrun();
    test_rst_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
